// File: rtl/cv32e40x_pkg.sv
// Shared types and constants for the cv32e40x load-store path.
// Holds the OBI data request layout, the memtype bit meanings and the
// posted-write buffer depth limit.
package cv32e40x_pkg;

    // memtype[0]: transfer may be posted (bufferable)
    // memtype[1]: transfer targets cacheable memory
    localparam int unsigned MEMTYPE_BUFFERABLE_BIT = 0;
    localparam int unsigned MEMTYPE_CACHEABLE_BIT  = 1;

    localparam logic [1:0] MEMTYPE_NONBUF_NONCACHE = 2'b00;
    localparam logic [1:0] MEMTYPE_BUF_NONCACHE    = 2'b01;
    localparam logic [1:0] MEMTYPE_NONBUF_CACHE    = 2'b10;
    localparam logic [1:0] MEMTYPE_BUF_CACHE       = 2'b11;

    // Largest legal depth for the multi-entry posted-write buffer.
    localparam int unsigned WBUF_DEPTH_MAX = 8;

    // OBI data-side request as produced by the load-store unit.
    typedef struct packed {
        logic [31:0] addr;
        logic [5:0]  atop;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic        we;
        logic [1:0]  memtype;
        logic [2:0]  prot;
        logic        dbg;
    } obi_data_req_t;

    // A transfer can be posted only if it is a write to bufferable memory.
    function automatic logic is_bufferable(input obi_data_req_t req);
        return req.memtype[MEMTYPE_BUFFERABLE_BIT] & req.we;
    endfunction

endpackage

// File: rtl/cv32e40x_write_buffer_fifo.sv
// Multi-entry posted-write buffer between the LSU and the OBI data port.
// Bufferable writes are queued in a circular FIFO; anything else waits
// upstream until the FIFO has drained, so downstream order always matches
// upstream acceptance order. An empty FIFO passes transfers straight through.
module cv32e40x_write_buffer_fifo
    import cv32e40x_pkg::*;
#(
    parameter  int unsigned DEPTH = 2,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,

    input  logic             valid_i,
    input  obi_data_req_t    trans_i,
    output logic             ready_o,

    output logic             valid_o,
    output obi_data_req_t    trans_o,
    input  logic             ready_i,

    output logic             empty_o,
    output logic [CNT_W-1:0] count_o
);

    localparam int unsigned      PTR_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(DEPTH - 1);

    if ((DEPTH < 1) || (DEPTH > WBUF_DEPTH_MAX)) begin : gen_depth_illegal
        $error("cv32e40x_write_buffer_fifo: DEPTH must be in 1..%0d", WBUF_DEPTH_MAX);
    end

    logic [CNT_W-1:0] count_q, count_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    obi_data_req_t    mem_q [DEPTH];

    logic bufferable;
    logic empty;
    logic full;
    logic push;
    logic pop;

    assign bufferable = is_bufferable(trans_i);
    assign empty      = (count_q == '0);
    assign full       = (count_q == DEPTH_CNT);

    // The head leaves whenever downstream accepts it. An empty FIFO with a
    // ready downstream bypasses, so a write is stored only when it cannot
    // leave in the same cycle or when older entries are still queued.
    assign pop  = !empty && ready_i;
    assign push = valid_i && bufferable && (empty ? !ready_i : (!full || ready_i));

    // Upstream handshake and downstream presentation; the head of the FIFO
    // takes precedence over the live request to preserve ordering.
    assign ready_o = empty ? (bufferable || ready_i) : (bufferable && (!full || ready_i));
    assign valid_o = !empty || valid_i;
    assign trans_o = empty ? trans_i : mem_q[rd_ptr_q];
    assign empty_o = empty;
    assign count_o = count_q;

    // Next-state for pointers and occupancy; pointers wrap by compare so any
    // depth works, not only powers of two.
    always_comb begin
        // NOTE: every variable gets a default before any branch, so no path
        // leaves it unassigned and no latch is inferred.
        count_d  = count_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;

        if (pop) begin
            rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + 1'b1;
        end

        if (push) begin
            wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
        end

        unique case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Control state register with synchronous reset; reset drops all entries.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values of its inputs.
        if (!rst_n) begin
            count_q  <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
        end else begin
            count_q  <= count_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
        end
    end

    // Entry storage, written at the write pointer on every push.
    always_ff @(posedge clk) begin
        // NOTE: the storage array has no reset; entries are only read while
        // count_q marks them valid, so their power-up contents never matter.
        if (push) begin
            mem_q[wr_ptr_q] <= trans_i;
        end
    end

    // Protocol and structural invariants.
    a_no_push_when_full: assert property (@(posedge clk) disable iff (!rst_n)
        !(push && full && !ready_i));

    a_no_pop_when_empty: assert property (@(posedge clk) disable iff (!rst_n)
        !(pop && empty));

    a_valid_while_occupied: assert property (@(posedge clk) disable iff (!rst_n)
        !empty |-> valid_o);

    a_trans_stable_until_ready: assert property (@(posedge clk) disable iff (!rst_n)
        (valid_o && !ready_i) |=> $stable(trans_o));

endmodule

// File: tb/tb_cv32e40x_write_buffer_fifo.sv
// Directed bench for the posted-write FIFO at depths 2, 3 and 1.
// Each instance has its own stimulus; idle instances see valid low.
module tb_cv32e40x_write_buffer_fifo;
    import cv32e40x_pkg::*;

    logic clk;
    logic rst_n;

    logic          v2, r2, rdy2, vo2, emp2;
    obi_data_req_t t2, to2;
    logic [1:0]    cnt2;

    logic          v3, r3, rdy3, vo3, emp3;
    obi_data_req_t t3, to3;
    logic [1:0]    cnt3;

    logic          v1, r1, rdy1, vo1, emp1;
    obi_data_req_t t1, to1;
    logic [0:0]    cnt1;

    int total;
    int bad;

    obi_data_req_t tr [16];

    cv32e40x_write_buffer_fifo #(.DEPTH(2)) u_d2 (
        .clk(clk), .rst_n(rst_n),
        .valid_i(v2), .trans_i(t2), .ready_o(rdy2),
        .valid_o(vo2), .trans_o(to2), .ready_i(r2),
        .empty_o(emp2), .count_o(cnt2)
    );

    cv32e40x_write_buffer_fifo #(.DEPTH(3)) u_d3 (
        .clk(clk), .rst_n(rst_n),
        .valid_i(v3), .trans_i(t3), .ready_o(rdy3),
        .valid_o(vo3), .trans_o(to3), .ready_i(r3),
        .empty_o(emp3), .count_o(cnt3)
    );

    cv32e40x_write_buffer_fifo #(.DEPTH(1)) u_d1 (
        .clk(clk), .rst_n(rst_n),
        .valid_i(v1), .trans_i(t1), .ready_o(rdy1),
        .valid_o(vo1), .trans_o(to1), .ready_i(r1),
        .empty_o(emp1), .count_o(cnt1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge, where inputs are driven.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic obi_data_req_t mk(input logic we, input logic [31:0] addr,
                                         input logic [31:0] data);
        obi_data_req_t req;
        req         = '0;
        req.addr    = addr;
        req.we      = we;
        req.be      = 4'hf;
        req.wdata   = data;
        req.memtype = we ? MEMTYPE_BUF_NONCACHE : MEMTYPE_NONBUF_NONCACHE;
        return req;
    endfunction

    // Depth-3 wrap run: which write is presented, expected ready and count.
    int sel3_tab [13] = '{0, 1, 2, 3, 4, 5, 6, 7, 7, 8, 8, 9, 9};
    int rdy3_tab [13] = '{1, 1, 1, 1, 1, 1, 1, 0, 1, 0, 1, 0, 1};
    int cnt3_tab [20] = '{0, 0, 1, 1, 2, 2, 3, 3, 3, 3, 3, 3, 3, 3, 3, 2, 2, 1, 1, 0};

    // Depth-1 sequence: valid, presented transfer, ready, then expectations.
    int v1_tab   [8] = '{1, 1, 1, 1, 1, 1, 1, 0};
    int s1_tab   [8] = '{0, 1, 1, 12, 12, 12, 2, 2};
    int r1_tab   [8] = '{0, 0, 1, 0, 1, 1, 1, 1};
    int er1_tab  [8] = '{1, 0, 1, 0, 0, 1, 1, 1};
    int ev1_tab  [8] = '{1, 1, 1, 1, 1, 1, 1, 0};
    int eo1_tab  [8] = '{0, 0, 0, 1, 1, 12, 2, 2};
    int ec1_tab  [8] = '{0, 1, 1, 1, 1, 0, 0, 0};

    initial begin
        int exp_idx;
        total = 0;
        bad   = 0;

        for (int i = 0; i < 12; i++) tr[i] = mk(1'b1, 32'h1000 + 32'(4 * i), 32'hA000_0000 + 32'(i));
        for (int i = 12; i < 16; i++) tr[i] = mk(1'b0, 32'h2000 + 32'(4 * i), 32'h0);

        rst_n = 1'b0;
        v1 = 1'b0; v2 = 1'b0; v3 = 1'b0;
        r1 = 1'b1; r2 = 1'b1; r3 = 1'b1;
        t1 = tr[0]; t2 = tr[0]; t3 = tr[0];
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        #2;

        // Reset state
        check("rst_d2_empty", 128'(emp2), 128'(1));
        check("rst_d2_count", 128'(cnt2), 128'(0));
        check("rst_d2_valid", 128'(vo2), 128'(0));
        check("rst_d2_trans", 128'(to2), 128'(t2));
        check("rst_d3_count", 128'(cnt3), 128'(0));
        check("rst_d1_empty", 128'(emp1), 128'(1));

        // Depth 2: A, B, C back-to-back with downstream stalled
        cyc(); v2 = 1'b1; r2 = 1'b0; t2 = tr[0]; #2;
        check("t1_a_ready", 128'(rdy2), 128'(1));
        check("t1_a_count", 128'(cnt2), 128'(0));
        check("t1_a_trans", 128'(to2), 128'(tr[0]));
        cyc(); t2 = tr[1]; #2;
        check("t1_b_ready", 128'(rdy2), 128'(1));
        check("t1_b_count", 128'(cnt2), 128'(1));
        cyc(); t2 = tr[2]; #2;
        check("t1_c_ready", 128'(rdy2), 128'(0));
        check("t1_c_count", 128'(cnt2), 128'(2));
        check("t1_c_trans", 128'(to2), 128'(tr[0]));
        cyc(); r2 = 1'b1; #2;
        check("t1_pp_ready", 128'(rdy2), 128'(1));
        check("t1_pp_trans", 128'(to2), 128'(tr[0]));
        cyc(); v2 = 1'b0; r2 = 1'b0; #2;
        check("t1_pp_count", 128'(cnt2), 128'(2));
        check("t1_head_b", 128'(to2), 128'(tr[1]));
        cyc(); r2 = 1'b1; #2;
        check("t1_drain_b", 128'(to2), 128'(tr[1]));
        cyc(); #2;
        check("t1_drain_c", 128'(to2), 128'(tr[2]));
        check("t1_drain_cnt", 128'(cnt2), 128'(1));
        cyc(); #2;
        check("t1_empty", 128'(emp2), 128'(1));
        check("t1_empty_valid", 128'(vo2), 128'(0));

        // Depth 2: read bypasses an empty buffer
        cyc(); v2 = 1'b1; r2 = 1'b1; t2 = tr[12]; #2;
        check("t2_ready", 128'(rdy2), 128'(1));
        check("t2_valid", 128'(vo2), 128'(1));
        check("t2_trans", 128'(to2), 128'(tr[12]));
        cyc(); v2 = 1'b0; #2;
        check("t2_count", 128'(cnt2), 128'(0));

        // Depth 2: read held behind two queued writes
        cyc(); v2 = 1'b1; r2 = 1'b0; t2 = tr[3]; #2;
        check("t3_d_ready", 128'(rdy2), 128'(1));
        cyc(); t2 = tr[4]; #2;
        check("t3_e_ready", 128'(rdy2), 128'(1));
        cyc(); t2 = tr[13]; r2 = 1'b1; #2;
        check("t3_rd_wait1", 128'(rdy2), 128'(0));
        check("t3_drain_d", 128'(to2), 128'(tr[3]));
        check("t3_cnt2", 128'(cnt2), 128'(2));
        cyc(); #2;
        check("t3_rd_wait2", 128'(rdy2), 128'(0));
        check("t3_drain_e", 128'(to2), 128'(tr[4]));
        cyc(); #2;
        check("t3_rd_empty", 128'(emp2), 128'(1));
        check("t3_rd_ready", 128'(rdy2), 128'(1));
        check("t3_rd_trans", 128'(to2), 128'(tr[13]));
        cyc(); v2 = 1'b0; #2;
        check("t3_count", 128'(cnt2), 128'(0));

        // Depth 2: reset while holding two entries
        cyc(); v2 = 1'b1; r2 = 1'b0; t2 = tr[5];
        cyc(); t2 = tr[6]; #2;
        check("t4_fill_cnt", 128'(cnt2), 128'(1));
        cyc(); v2 = 1'b0; rst_n = 1'b0; #2;
        check("t4_pre_rst_cnt", 128'(cnt2), 128'(2));
        cyc(); rst_n = 1'b1; #2;
        check("t4_rst_empty", 128'(emp2), 128'(1));
        check("t4_rst_count", 128'(cnt2), 128'(0));
        check("t4_rst_valid", 128'(vo2), 128'(0));
        cyc(); v2 = 1'b1; t2 = tr[14]; #2;
        check("t4_rd_valid", 128'(vo2), 128'(1));
        check("t4_rd_trans", 128'(to2), 128'(tr[14]));
        check("t4_rd_wait", 128'(rdy2), 128'(0));
        cyc(); r2 = 1'b1; #2;
        check("t4_rd_ready", 128'(rdy2), 128'(1));
        check("t4_rd_nostale", 128'(to2), 128'(tr[14]));
        cyc(); v2 = 1'b0; #2;
        check("t4_end_cnt", 128'(cnt2), 128'(0));

        // Depth 3: ten writes with downstream ready toggling, pointer wrap
        exp_idx = 0;
        for (int c = 0; c < 20; c++) begin
            cyc();
            r3 = (c % 2 == 0);
            v3 = (c <= 12);
            t3 = tr[sel3_tab[(c <= 12) ? c : 12]];
            #2;
            if (c <= 12) check($sformatf("d3_ready_c%0d", c), 128'(rdy3), 128'(rdy3_tab[c]));
            check($sformatf("d3_count_c%0d", c), 128'(cnt3), 128'(cnt3_tab[c]));
            if (vo3 && r3) begin
                check($sformatf("d3_order_%0d", exp_idx), 128'(to3), 128'(tr[exp_idx]));
                exp_idx++;
            end
        end
        cyc(); v3 = 1'b0; r3 = 1'b1; #2;
        check("d3_delivered", 128'(exp_idx), 128'(10));
        check("d3_empty", 128'(emp3), 128'(1));

        // Depth 1: single-word buffer behaviour
        for (int c = 0; c < 8; c++) begin
            cyc();
            v1 = 1'(v1_tab[c]);
            r1 = 1'(r1_tab[c]);
            t1 = tr[s1_tab[c]];
            #2;
            check($sformatf("d1_ready_c%0d", c), 128'(rdy1), 128'(er1_tab[c]));
            check($sformatf("d1_valid_c%0d", c), 128'(vo1), 128'(ev1_tab[c]));
            check($sformatf("d1_trans_c%0d", c), 128'(to1), 128'(tr[eo1_tab[c]]));
            check($sformatf("d1_count_c%0d", c), 128'(cnt1), 128'(ec1_tab[c]));
        end

        cyc();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cv32e40x_write_buffer_fifo.md
Name: cv32e40x_write_buffer_fifo

Overview:
- Multi-entry posted-write buffer between the load-store unit and the OBI data interface.
- Generalises the single-word write buffer to DEPTH entries in a circular FIFO.
- Buffers only bufferable writes: memtype[0]=1 and we=1.
- Strict ordering: any read or non-bufferable transfer is held upstream until the FIFO has fully drained. empty_o/count_o expose drain state for fence and debug logic.

Parameters:
DEPTH, 2, number of buffered write entries; legal range 1..8; elaboration error otherwise.
CNT_W, $clog2(DEPTH+1), localparam, width of count_o; not user-overridable.

Ports:
clk  input  1  clock
rst_n  input  1  reset; synchronous, active-low (the reset polarity and synchronicity are already decided)
valid_i  input  1  upstream request valid
trans_i  input  obi_data_req_t  upstream request
ready_o  output  1  upstream request accepted
valid_o  output  1  downstream request valid
trans_o  output  obi_data_req_t  downstream request
ready_i  input  1  downstream (OBI gnt) ready
empty_o  output  1  FIFO holds no entries
count_o  output  CNT_W  number of occupied entries

Behaviour:
- Definitions:
  - bufferable = trans_i.memtype[0] && trans_i.we.
  - empty = (count==0); full = (count==DEPTH).
- State: count, rd_ptr, wr_ptr.
  - All reset to 0 on a clk edge with rst_n=0.
  - Storage array is not reset.
  - Reset mid-operation discards all entries immediately; nothing is replayed.
- Outputs, all combinational from state and inputs:
  - valid_o = !empty || valid_i.
  - trans_o = empty ? trans_i : mem[rd_ptr].
  - ready_o = empty ? (bufferable || ready_i) : (bufferable && (!full || ready_i)).
  - empty_o = empty; count_o = count.
  - After reset: empty_o=1, count_o=0, valid_o=valid_i, trans_o=trans_i.
- Bypass: if empty && valid_i && ready_i, the transfer passes straight through with zero latency and is not stored. Applies to any transfer type.
- pop = !empty && ready_i.
  - Advances rd_ptr.
  - Head entry is the one presented on trans_o this cycle.
- push = valid_i && bufferable && (empty ? !ready_i : (!full || ready_i)).
  - Writes trans_i into mem[wr_ptr] and advances wr_ptr.
  - Upstream sees the write as accepted (ready_o=1) in the same cycle.
- Count update:
  - push && !pop: count+1.
  - pop && !push: count-1.
  - Both or neither: unchanged.
  - count never exceeds DEPTH and never underflows.
- Full plus pop: a simultaneous push is allowed. Count stays DEPTH; both pointers advance.
- Pointer wrap: explicit compare, so DEPTH-1 -> 0; DEPTH need not be a power of 2.
- Non-bufferable or read transfer while !empty: ready_o=0. Upstream must hold valid_i and trans_i stable (OBI rule). The transfer bypasses once empty.
- Ordering: downstream sees transfers in upstream acceptance order; no reordering, merging or forwarding.
- DEPTH=1: identical cycle behaviour to the single-word buffer for writes.
- Assertions:
  - No push when full && !ready_i.
  - No pop when empty.
  - valid_o stays high while !empty.
  - trans_o stable while valid_o && !ready_i.

Decomposition:
- obi_data_req_t and the memtype encodings stay in cv32e40x_pkg.
- Add a package constant WBUF_DEPTH_MAX = 8 for the parameter check.
- The single-word state enum is not used by this block.
- No sub-module: pointers, counter and storage fit inline (≈150 lines).

Test Plan:
- DEPTH=2, ready_i=0, three back-to-back bufferable writes A, B, C.
  - A and B accepted, count_o 1 then 2.
  - C sees ready_o=0.
  - Raise ready_i for one cycle: trans_o=A, C is accepted in the same cycle, count stays 2; next trans_o=B.
- Empty, ready_i=1, non-bufferable read.
  - ready_o=1, valid_o=1, trans_o==trans_i in the same cycle.
  - count_o stays 0.
- Buffer holds 2 writes, upstream presents a read with ready_i=1.
  - ready_o=0 for 2 cycles while writes drain in order.
  - Read bypasses on cycle 3 with empty_o=1.
- DEPTH=3 wrap: 10 writes with ready_i toggling 1010….
  - Downstream order equals issue order.
  - count_o never exceeds 3.
  - Pointers pass through 2 -> 0 with no corruption.
- Reset with count_o=2: assert rst_n=0 for one clk edge.
  - Next cycle empty_o=1, count_o=0, valid_o=valid_i.
  - The stale entries are never driven.
- DEPTH=1 regression: replay the single-word buffer's write test sequence.
  - Cycle-identical valid_o, ready_o and trans_o.
